// File: rtl/vram_stream.sv
// rtl/vram_stream.sv - banked circular pixel buffer between pixel writer and video timing generator
// Show-ahead head with fill/hold underflow policy, frame progress and sync-loss tracking.
module vram_stream #(
  parameter int          PIX_W    = 24,
  parameter int          AW       = 16,
  parameter int          BANKS    = 2,
  parameter logic [23:0] FILL_PIX = 24'hFF0000
) (
  input  logic                               clk_sys,
  input  logic                               vram_reset,
  input  logic [23:0]                        frame_pixels,
  input  logic                               hold_mode,
  input  logic                               wr_req,
  input  logic [PIX_W-1:0]                   wr_data,
  output logic                               wr_ready,
  input  logic                               ce_pix,
  input  logic                               rd_en,
  input  logic                               rd_frame_start,
  output logic [PIX_W-1:0]                   pixel,
  output logic [AW+$clog2(BANKS):0]          queue,
  output logic [23:0]                        frame_cnt,
  output logic                               end_frame,
  output logic                               synced,
  output logic [15:0]                        underflow_cnt
);

  localparam int BW  = $clog2(BANKS);
  localparam int PW  = AW + BW;
  localparam int QW  = PW + 1;
  localparam int BSW = BW + 1;
  localparam logic [PIX_W-1:0] FILL = PIX_W'(FILL_PIX);

  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [PW-1:0]              rd_addr;
  logic [QW-1:0]              avail;
  logic                       wr_d1;
  logic [PIX_W-1:0]           last;
  logic [PIX_W-1:0]           head;
  logic [BSW-1:0]             rd_bank_q;
  logic [BANKS-1:0][PIX_W-1:0] bank_q;

  logic wr_acc;
  logic pop;
  logic underflow;
  logic [PW:0]    wr_ext;
  logic [PW:0]    rd_ext;
  logic [BSW-1:0] wr_bank;
  logic [BSW-1:0] rd_bank;

  // queue can never exceed DEPTH = 2^PW, so its MSB alone flags "full"
  assign wr_ready  = ~queue[PW];
  assign end_frame = (frame_cnt >= frame_pixels);
  assign wr_acc    = wr_req && wr_ready;
  assign pop       = ce_pix && rd_en && (avail != '0);
  assign underflow = ce_pix && rd_en && (avail == '0);

  // RAMs read every cycle at the post-pop head address, so bank_q is the head
  assign rd_addr = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign wr_ext  = {1'b0, wr_ptr};
  assign rd_ext  = {1'b0, rd_addr};
  assign wr_bank = wr_ext[PW:AW];
  assign rd_bank = rd_ext[PW:AW];

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [PIX_W-1:0] mem [2**AW];
    logic [PIX_W-1:0] q;
    always_ff @(posedge clk_sys) begin
      if (wr_acc && (wr_bank == BSW'(b)))
        mem[wr_ptr[AW-1:0]] <= wr_data;
      q <= mem[rd_addr[AW-1:0]];
    end
    assign bank_q[b] = q;
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < BANKS; i++)
      if (rd_bank_q == BSW'(i))
        head = bank_q[i];
  end

  // avail lags queue by the RAM write-to-head latency of accepted writes
  always_ff @(posedge clk_sys) begin
    if (vram_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      queue         <= '0;
      avail         <= '0;
      wr_d1         <= 1'b0;
      rd_bank_q     <= '0;
      frame_cnt     <= '0;
      pixel         <= '0;
      last          <= '0;
      synced        <= 1'b1;
      underflow_cnt <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr    <= wr_ptr + 1'b1;
        frame_cnt <= end_frame ? 24'd1 : frame_cnt + 24'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      queue     <= queue + QW'(wr_acc) - QW'(pop);
      avail     <= avail + QW'(wr_d1) - QW'(pop);
      wr_d1     <= wr_acc;
      rd_bank_q <= rd_bank;
      if (ce_pix) begin
        if (!rd_en) begin
          pixel <= '0;
        end else if (pop) begin
          pixel <= head;
          last  <= head;
        end else begin
          pixel <= hold_mode ? last : FILL;
          if (underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
        end
      end
      if (underflow)
        synced <= 1'b0;
      else if (rd_frame_start && (queue != '0))
        synced <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_stream.sv
// tb/tb_vram_stream.sv - scoreboard bench for vram_stream
// Stimulus pushes expected pixels; a monitor pops and compares after each read.
module tb_vram_stream;

  logic        clk_sys = 1'b0;
  logic        vram_reset;
  logic [23:0] frame_pixels;
  logic        hold_mode;
  logic        wr_req;
  logic [23:0] wr_data;
  logic        wr_ready;
  logic        ce_pix;
  logic        rd_en;
  logic        rd_frame_start;
  logic [23:0] pixel;
  logic [5:0]  queue;
  logic [23:0] frame_cnt;
  logic        end_frame;
  logic        synced;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q [$];
  logic        rd_seen = 1'b0;

  vram_stream #(.PIX_W(24), .AW(4), .BANKS(2), .FILL_PIX(24'hFF0000)) dut (
    .clk_sys(clk_sys), .vram_reset(vram_reset), .frame_pixels(frame_pixels),
    .hold_mode(hold_mode), .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready),
    .ce_pix(ce_pix), .rd_en(rd_en), .rd_frame_start(rd_frame_start), .pixel(pixel),
    .queue(queue), .frame_cnt(frame_cnt), .end_frame(end_frame), .synced(synced),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle();
    wr_req = 1'b0; ce_pix = 1'b0; rd_en = 1'b0; rd_frame_start = 1'b0;
  endtask

  task automatic rd(input logic [23:0] exp);
    ce_pix = 1'b1; rd_en = 1'b1;
    exp_q.push_back(exp);
  endtask

  always @(posedge clk_sys) rd_seen <= ce_pix && rd_en && !vram_reset;

  always @(negedge clk_sys) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected: got %h expected none", pixel);
      end else begin
        chk("pixel", {8'h0, pixel}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vram_reset = 1'b1; frame_pixels = 24'd100; hold_mode = 1'b0; wr_data = '0;
    idle();
    cyc(); cyc();
    vram_reset = 1'b0;
    chk("rst_queue", 32'(queue), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_end_frame", 32'(end_frame), 0);
    chk("rst_synced", 32'(synced), 1);
    chk("rst_underflow", 32'(underflow_cnt), 0);

    // fill to DEPTH, then a dropped write
    for (int i = 1; i <= 32; i++) begin
      wr_req = 1'b1; wr_data = 24'(i);
      cyc();
    end
    chk("full_queue", 32'(queue), 32);
    chk("full_wr_ready", 32'(wr_ready), 0);
    wr_data = 24'h000099;
    cyc();
    wr_req = 1'b0;
    chk("drop_queue", 32'(queue), 32);
    chk("drop_frame_cnt", 32'(frame_cnt), 32);

    // drain back-to-back across the bank boundary and the wrap
    for (int i = 1; i <= 32; i++) begin
      rd(24'(i));
      cyc();
      if (i == 1) begin
        chk("unfull_wr_ready", 32'(wr_ready), 1);
        chk("unfull_queue", 32'(queue), 31);
      end
    end
    rd_en = 1'b0;
    cyc();
    chk("blank_pixel", 32'(pixel), 0);
    chk("drained_queue", 32'(queue), 0);
    idle();

    // underflow with fill colour, then resync
    for (int i = 0; i < 3; i++) begin
      rd(24'hFF0000);
      cyc();
    end
    idle();
    cyc();
    chk("uf_cnt3", 32'(underflow_cnt), 3);
    chk("uf_synced", 32'(synced), 0);
    chk("ce_hold_pixel", 32'(pixel), 32'hFF0000);
    wr_req = 1'b1; wr_data = 24'hABCDEF;
    cyc();
    idle();
    chk("one_queue", 32'(queue), 1);
    chk("presync_synced", 32'(synced), 0);
    rd_frame_start = 1'b1;
    cyc();
    idle();
    chk("resync_synced", 32'(synced), 1);
    rd(24'hABCDEF);
    cyc();
    idle();

    // hold mode repeats the last good pixel
    hold_mode = 1'b1;
    wr_req = 1'b1; wr_data = 24'h123456;
    cyc();
    idle();
    cyc();
    for (int i = 0; i < 3; i++) begin
      rd(24'h123456);
      cyc();
    end
    idle();
    cyc();
    chk("hold_uf_cnt", 32'(underflow_cnt), 5);

    // word written at t is not poppable at t+1, poppable at t+2
    wr_req = 1'b1; wr_data = 24'h777777;
    cyc();
    wr_req = 1'b0;
    rd(24'h123456);
    cyc();
    rd(24'h777777);
    cyc();
    idle();
    cyc();
    chk("latency_uf_cnt", 32'(underflow_cnt), 6);
    chk("latency_queue", 32'(queue), 0);

    // frame counter wraps at frame_pixels
    hold_mode = 1'b0;
    frame_pixels = 24'd4;
    #1;
    chk("stale_end_frame", 32'(end_frame), 1);
    for (int k = 1; k <= 9; k++) begin
      wr_req = 1'b1; wr_data = 24'h100 + 24'(k);
      cyc();
      chk("frame_cnt", 32'(frame_cnt), 32'(((k - 1) % 4) + 1));
      chk("end_frame", 32'(end_frame), 32'((((k - 1) % 4) + 1) == 4));
    end
    wr_data = 24'h10A;
    cyc();
    wr_req = 1'b0;
    chk("ten_queue", 32'(queue), 10);

    // 5 pops with 3 concurrent writes, then reset mid-stream
    for (int j = 0; j < 5; j++) begin
      rd(24'h101 + 24'(j));
      wr_req = (j < 3); wr_data = 24'h200 + 24'(j);
      cyc();
    end
    idle();
    chk("mix_queue", 32'(queue), 8);
    vram_reset = 1'b1;
    wr_req = 1'b1; ce_pix = 1'b1; rd_en = 1'b1; rd_frame_start = 1'b1;
    cyc();
    vram_reset = 1'b0;
    idle();
    chk("mid_rst_queue", 32'(queue), 0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 1);
    chk("mid_rst_pixel", 32'(pixel), 0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("mid_rst_end_frame", 32'(end_frame), 0);
    chk("mid_rst_synced", 32'(synced), 1);
    chk("mid_rst_underflow", 32'(underflow_cnt), 0);
    rd(24'hFF0000);
    cyc();
    idle();
    cyc();
    chk("post_rst_uf_cnt", 32'(underflow_cnt), 1);
    chk("post_rst_synced", 32'(synced), 0);
    cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_stream.md
# vram_stream

Parametrised pixel stream buffer for the Groovy video path. It sits between the pixel writer (network/DDR side) and the video timing generator. It stores incoming pixels in a circular buffer of BANKS equal RAM banks, with the bank count and size set by parameters. The timing generator drains it one pixel per active `ce_pix`, and the block reports occupancy, per-frame write progress, sync loss and underflow statistics. Compared with the fixed two-bank 24-bit buffer it replaces, it adds:

- configurable pixel width, bank depth and bank count;
- a run-time underflow policy (fill colour or hold last pixel);
- resynchronisation at frame start;
- a saturating underflow counter.

## Interface
Parameters:
- PIX_W, 24, pixel width in bits (R:G:B packed MSB first).
- AW, 16, address width per bank; bank depth = 2^AW words.
- BANKS, 2, number of banks, power of two, 1..8; DEPTH = BANKS*2^AW.
- FILL_PIX, 24'hFF0000, pixel emitted on underflow when hold_mode=0, truncated or zero-extended to PIX_W.

Ports (name, direction, width, meaning). One clock `clk_sys`; reset `vram_reset` is synchronous and active-high.
- clk_sys, in, 1, system clock.
- vram_reset, in, 1, synchronous active-high reset.
- frame_pixels, in, 24, pixels per frame, precomputed upstream as (H*V)>>interlaced.
- hold_mode, in, 1, underflow policy: 0 = emit FILL_PIX, 1 = repeat the last pixel read.
- wr_req, in, 1, write strobe.
- wr_data, in, PIX_W, pixel to store.
- wr_ready, out, 1, buffer can accept a write this cycle.
- ce_pix, in, 1, pixel clock enable.
- rd_en, in, 1, consume one pixel on this ce_pix (visible area and active).
- rd_frame_start, in, 1, one-cycle pulse at start of a displayed frame (vblank end).
- pixel, out, PIX_W, registered output pixel; 0 during blanking.
- queue, out, AW+log2(BANKS)+1, words currently stored.
- frame_cnt, out, 24, pixels written in the current frame.
- end_frame, out, 1, frame_cnt >= frame_pixels.
- synced, out, 1, no underflow since the last resync.
- underflow_cnt, out, 16, saturating count of underflowed reads.

## Operation
- Storage is a circular buffer of DEPTH words.
  - Global pointer bits [AW-1:0] address a word within a bank; the upper bits select the bank.
  - Each bank is a simple dual-port RAM with a 1-cycle registered read.
  - wr_ptr and rd_ptr wrap from DEPTH-1 to 0 and cross bank boundaries transparently.
- Write: accepted when wr_req && wr_ready.
  - wr_ready = (queue < DEPTH).
  - An accepted write stores wr_data at wr_ptr and advances wr_ptr.
  - frame_cnt <= end_frame ? 1 : frame_cnt+1.
  - A write while wr_ready=0 is dropped with no state change.
- Read: a show-ahead head register holds the word at rd_ptr whenever queue > 0. It is refilled from RAM after each pop. On each ce_pix:
  - rd_en=1 and queue>0: pixel <= head, pop (rd_ptr+1, queue-1), last <= head.
  - rd_en=1 and queue=0 (underflow): pixel <= hold_mode ? last : FILL_PIX; synced <= 0; underflow_cnt += 1, saturating at 16'hFFFF.
  - rd_en=0: pixel <= 0.
- When ce_pix=0, pixel holds its value and no pop occurs.
- Resync: on rd_frame_start, if queue>0 then synced <= 1. Otherwise synced is unchanged.
- Occupancy rules:
  - queue tracks accepted writes minus pops.
  - A word written in cycle t is poppable from cycle t+2, after RAM latency and head refill.
  - Until then the buffer reads as empty for underflow purposes.
  - A simultaneous push and pop leaves queue unchanged.
- If frame_pixels=0, end_frame is 1 constantly and frame_cnt is 1 after every write.

## Timing
- Reset values: pointers 0, queue 0, frame_cnt 0, pixel 0, last 0, head invalid, synced 1, underflow_cnt 0.
- Reset derived outputs: wr_ready 1; end_frame follows the comparison (frame_cnt=0, so 1 only when frame_pixels=0).
- Reset has priority over every other input in the same cycle. Asserting reset mid-frame discards all stored data.
- Latencies:
  - Write to poppable: 2 cycles.
  - rd_en on ce_pix to pixel: 1 cycle (registered).
  - queue, wr_ready, frame_cnt, end_frame update on the edge following the accepted write or pop.
- Full boundary: at queue=DEPTH, wr_ready=0. A pop in that cycle makes wr_ready=1 in the next cycle, never the same cycle.
- Wrap boundary: rd_ptr and wr_ptr moving from DEPTH-1 to 0 must not insert bubbles. Back-to-back pops across a bank boundary deliver consecutive pixels on consecutive ce_pix.
- Simultaneous events: if an underflow and rd_frame_start occur in the same cycle, the underflow wins and synced=0.

## Test plan
- Bench parameters: BANKS=2, AW=4, DEPTH=32, PIX_W=24.
- Write 32 pixels 0x000001..0x000020 with no reads -> wr_ready=0 after the 32nd write and queue=32. A 33rd wr_req is dropped.
- From full, drain with rd_en=1 and ce_pix=1 every cycle -> pixel = 0x000001..0x000020 on consecutive cycles, including across the bank 0→1 boundary. queue reaches 0.
- Empty buffer, hold_mode=0, 3 reads -> pixel = 0xFF0000 three times, underflow_cnt=3, synced=0. Then write 1 word and pulse rd_frame_start after queue=1 -> synced=1.
- hold_mode=1: write 0x123456, read it, then read twice more with queue empty -> pixel = 0x123456, 0x123456, 0x123456, and underflow_cnt increments by 2.
- frame_pixels=4, write 9 pixels -> frame_cnt sequence 1,2,3,4,1,2,3,4,1. end_frame=1 exactly while frame_cnt=4.
- Fill 10 words, run 5 pops and 3 concurrent writes, assert vram_reset for one cycle -> all outputs at reset values next cycle. Next read underflows with fill colour.
